// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 round-key buffer: sizes and the
// controller state encoding.
package aes_pkg;

  localparam int AES128_NR  = 10;
  localparam int AES128_NRK = AES128_NR + 1;
  localparam int AES128_KW  = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FILL,
    ST_READY
  } rk_state_e;

endpackage

// File: rtl/aes_rk_ram.sv
// Round-key store: one write port and one synchronous read port whose
// registered output is the round-key bus seen by the cipher cores.
module aes_rk_ram #(
  parameter int DEPTH = 11,
  parameter int KW    = 128,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [KW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          rzero,
  output logic [KW-1:0] rdata
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [KW-1:0] mem_q [DEPTH];
  logic [KW-1:0] rdata_q;
  logic [AW-1:0] ridx;

  // Out-of-range indices are folded onto entry 0; the parent zeroes that result anyway.
  assign ridx = (raddr <= LAST) ? raddr : '0;

  // NOTE: the key store is deliberately left out of reset; validity is
  // tracked by the controller, so a reset only needs to hide the contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= rzero ? '0 : mem_q[ridx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/aes_rk_buffer_128.sv
// Drives the AES-128 key expander, captures its 11 round keys into a store
// and serves indexed round-key reads with one cycle of latency.
module aes_rk_buffer_128
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR,
  parameter int KW = AES128_KW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] key_in,
  output logic [KW-1:0] exp_key,
  output logic          exp_kld,
  input  logic [31:0]   exp_w0,
  input  logic [31:0]   exp_w1,
  input  logic [31:0]   exp_w2,
  input  logic [31:0]   exp_w3,
  output logic          busy,
  output logic          ready,
  input  logic          rd_en,
  input  logic [3:0]    rd_idx,
  output logic          rd_ack,
  output logic          rd_err,
  output logic [KW-1:0] rk_out
);

  localparam int         NRK      = NR + 1;
  localparam logic [3:0] LAST_IDX = 4'(NR);

  rk_state_e     state_q;
  logic [3:0]    cnt_q;
  logic [KW-1:0] exp_key_q;
  logic          exp_kld_q;
  logic          busy_q;
  logic          ready_q;
  logic          rd_ack_q;
  logic          rd_err_q;

  logic          rd_bad;
  logic          mem_we;

  // Read decisions use the registered ready, so a read racing a restart still sees the old keys.
  assign rd_bad = !ready_q || (rd_idx > LAST_IDX);
  assign mem_we = (state_q == ST_FILL);

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      exp_key_q <= '0;
      exp_kld_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      rd_ack_q  <= rd_en;
      rd_err_q  <= rd_en && rd_bad;
      exp_kld_q <= 1'b0;

      case (state_q)
        ST_IDLE, ST_READY: begin
          if (start) begin
            exp_key_q <= key_in;
            exp_kld_q <= 1'b1;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt_q   <= '0;
          state_q <= ST_FILL;
        end
        ST_FILL: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_READY;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign exp_key = exp_key_q;
  assign exp_kld = exp_kld_q;
  assign busy    = busy_q;
  assign ready   = ready_q;
  assign rd_ack  = rd_ack_q;
  assign rd_err  = rd_err_q;

  aes_rk_ram #(
    .DEPTH (NRK),
    .KW    (KW),
    .AW    (4)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (cnt_q),
    .wdata ({exp_w0, exp_w1, exp_w2, exp_w3}),
    .re    (rd_en),
    .raddr (rd_idx),
    .rzero (rd_bad),
    .rdata (rk_out)
  );

endmodule

// File: tb/tb_aes_rk_buffer_128.sv
// Directed bench for aes_rk_buffer_128 with a behavioural AES-128 key
// expander attached to the exp_* interface.
module tb_aes_rk_buffer_128;

  localparam logic [127:0] KEY1    = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] K1_RK1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] K1_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] KEY2    = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] K2_RK10 = 128'h13111d7f_e3944a17_f307a78b_4d2b30c5;

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         start  = 1'b0;
  logic [127:0] key_in = '0;
  logic         rd_en  = 1'b0;
  logic [3:0]   rd_idx = '0;

  logic [127:0] exp_key;
  logic         exp_kld;
  logic [31:0]  exp_w0, exp_w1, exp_w2, exp_w3;
  logic         busy, ready, rd_ack, rd_err;
  logic [127:0] rk_out;

  int checks     = 0;
  int errors     = 0;
  int kld_pulses = 0;
  int cyc;

  logic [7:0]   sbox [256];
  logic [127:0] rk_model [11];
  logic [127:0] xw_q = '0;
  logic [3:0]   xr_q = '0;

  always #5 clk = ~clk;

  aes_rk_buffer_128 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key_in  (key_in),
    .exp_key (exp_key),
    .exp_kld (exp_kld),
    .exp_w0  (exp_w0),
    .exp_w1  (exp_w1),
    .exp_w2  (exp_w2),
    .exp_w3  (exp_w3),
    .busy    (busy),
    .ready   (ready),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_ack  (rd_ack),
    .rd_err  (rd_err),
    .rk_out  (rk_out)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0: return 8'h01;
      4'd1: return 8'h02;
      4'd2: return 8'h04;
      4'd3: return 8'h08;
      4'd4: return 8'h10;
      4'd5: return 8'h20;
      4'd6: return 8'h40;
      4'd7: return 8'h80;
      4'd8: return 8'h1b;
      4'd9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] rk, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = rk;
    t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rcon(r), 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Behavioural expander: loads on kld, otherwise advances one round per clock.
  always @(posedge clk) begin
    if (exp_kld) begin
      xw_q <= exp_key;
      xr_q <= '0;
    end else begin
      xw_q <= next_rk(xw_q, xr_q);
      xr_q <= xr_q + 4'd1;
    end
  end
  assign {exp_w0, exp_w1, exp_w2, exp_w3} = xw_q;

  always @(posedge clk) begin
    if (exp_kld) kld_pulses <= kld_pulses + 1;
  end

  a_kld_width : assert property (@(posedge clk) disable iff (rst) exp_kld |=> !exp_kld)
    else begin errors++; $error("FAIL kld_width observed=wide expected=one_cycle"); end
  a_kld_busy : assert property (@(posedge clk) disable iff (rst) exp_kld |-> busy)
    else begin errors++; $error("FAIL kld_outside_load observed=kld_without_busy expected=busy"); end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
  endtask

  task automatic do_read(input logic [3:0] idx);
    rd_en  = 1'b1;
    rd_idx = idx;
    tick();
    rd_en  = 1'b0;
  endtask

  task automatic start_key(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_read(input string tag, input logic err, input logic [127:0] rk);
    check({tag, "_ack"}, rd_ack, 1'b1);
    check({tag, "_err"}, rd_err, err);
    check({tag, "_rk"}, rk_out, rk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] inv, s;
      inv = '0;
      for (int j = 1; j < 256; j++) begin
        if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[i] = s;
    end
    rk_model[0] = KEY2;
    for (int i = 1; i < 11; i++) rk_model[i] = next_rk(rk_model[i-1], 4'(i - 1));

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_kld", exp_kld, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_ack", rd_ack, 1'b0);
    check("rst_err", rd_err, 1'b0);
    check("rst_exp_key", exp_key, '0);
    check("rst_rk_out", rk_out, '0);
    rst = 1'b0;
    do_read(4'd0);
    check_read("rd_before_start", 1'b1, '0);

    // Key 1: start-to-ready latency and first/last round keys
    start_key(KEY1);
    check("t1_kld_e0", exp_kld, 1'b1);
    check("t1_busy_e0", busy, 1'b1);
    check("t1_exp_key", exp_key, KEY1);
    tick();
    check("t1_kld_e1", exp_kld, 1'b0);
    wait_ready(cyc);
    check("t1_latency", 128'(cyc + 1), 128'd12);
    check("t1_busy_done", busy, 1'b0);
    do_read(4'd0);
    check_read("t1_rd0", 1'b0, KEY1);
    do_read(4'd1);
    check_read("t1_rd1", 1'b0, K1_RK1);
    do_read(4'd10);
    check_read("t1_rd10", 1'b0, K1_RK10);

    // Restart with key 2; concurrent read still returns key-1 data
    key_in = KEY2;
    start  = 1'b1;
    rd_en  = 1'b1;
    rd_idx = 4'd1;
    tick();
    start  = 1'b0;
    rd_en  = 1'b0;
    check_read("t2_rd_on_restart", 1'b0, K1_RK1);
    check("t2_ready_drop", ready, 1'b0);
    tick();
    tick();
    do_read(4'd5);
    check_read("t3_rd_in_fill", 1'b1, '0);
    check("t3_busy_in_fill", busy, 1'b1);
    wait_ready(cyc);
    check("t2_latency", 128'(cyc + 3), 128'd12);
    do_read(4'd10);
    check_read("t2_rd10", 1'b0, K2_RK10);
    do_read(4'd11);
    check_read("t3_rd_idx11", 1'b1, '0);
    do_read(4'd15);
    check_read("t3_rd_idx15", 1'b1, '0);

    // Back-to-back descending reads
    rd_en = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      rd_idx = 4'(i);
      tick();
      check_read($sformatf("t2_b2b_%0d", i), 1'b0, rk_model[i]);
    end
    rd_en = 1'b0;
    tick();
    check("t2_ack_drop", rd_ack, 1'b0);

    // Start while busy is ignored
    start_key(KEY1);
    tick();
    tick();
    tick();
    tick();
    start_key(KEY2);
    check("t4_exp_key_kept", exp_key, KEY1);
    check("t4_busy", busy, 1'b1);
    wait_ready(cyc);
    check("t4_latency", 128'(cyc + 5), 128'd12);
    do_read(4'd1);
    check_read("t4_rd1", 1'b0, K1_RK1);
    do_read(4'd10);
    check_read("t4_rd10", 1'b0, K1_RK10);

    // Reset in the middle of FILL (cnt == 6)
    start_key(KEY2);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", busy, 1'b0);
    check("t5_ready", ready, 1'b0);
    check("t5_kld", exp_kld, 1'b0);
    do_read(4'd0);
    check_read("t5_rd0", 1'b1, '0);
    tick();
    tick();
    tick();
    check("t5_stays_idle", {busy, ready}, 2'b00);
    do_read(4'd10);
    check_read("t5_rd10", 1'b1, '0);
    start_key(KEY2);
    wait_ready(cyc);
    check("t5_latency", 128'(cyc), 128'd12);
    do_read(4'd10);
    check_read("t5_rd10_after", 1'b0, K2_RK10);
    do_read(4'd4);
    check_read("t5_rd4_after", 1'b0, rk_model[4]);

    // One kld pulse per accepted start (5 accepted, 1 ignored)
    check("kld_pulse_count", 128'(kld_pulses), 128'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
